// File: rtl/pl_mon_pkg.sv
// Shared types and default parameters for the PL clock/reset health monitor.
//   win_state_t : measurement-window FSM states (top level)
//   ch_state_t  : per-channel monitored-reset FSM states
package pl_mon_pkg;

    localparam int unsigned DefNumCh      = 4;
    localparam int unsigned DefWindow     = 1024;
    localparam int unsigned DefCntW       = 16;
    localparam int unsigned DefSyncStages = 2;

    typedef enum logic {
        WinIdle,
        WinMeasure
    } win_state_t;

    typedef enum logic {
        ChInReset,
        ChRunning
    } ch_state_t;

endpackage

// File: rtl/pl_mon_channel.sv
// One monitored channel: synchronizes the monitored toggle and reset, counts toggle
// transitions over the window supplied by the top level, tracks reset de-assertion
// time and reset glitches, and checks qualified counts against [cfg_min, cfg_max].
//   pl_clk0, pl_reset     : reference clock, async active-high reset
//   clr_err               : clears freq_err / rst_glitch (a same-cycle set wins)
//   win_run, win_end      : window active this cycle / last cycle of the window
//   mon_tick, mon_resetn  : raw inputs from the monitored domain
//   cfg_min, cfg_max      : bounds for the window count
//   meas_cnt              : count latched at the last window end
//   freq_err, rst_glitch  : sticky error flags
//   rst_state             : synchronized reset status (1 = in reset)
//   deassert_cnt          : cycles since reset de-assertion, saturating
module pl_mon_channel
    import pl_mon_pkg::*;
#(
    parameter int unsigned CNT_W       = DefCntW,
    parameter int unsigned SYNC_STAGES = DefSyncStages
) (
    input  logic             pl_clk0,
    input  logic             pl_reset,
    input  logic             clr_err,
    input  logic             win_run,
    input  logic             win_end,
    input  logic             mon_tick,
    input  logic             mon_resetn,
    input  logic [CNT_W-1:0] cfg_min,
    input  logic [CNT_W-1:0] cfg_max,
    output logic [CNT_W-1:0] meas_cnt,
    output logic             freq_err,
    output logic             rst_state,
    output logic [CNT_W-1:0] deassert_cnt,
    output logic             rst_glitch
);

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic [SYNC_STAGES-1:0] tick_sync_q, tick_sync_d;
    logic [SYNC_STAGES-1:0] rstn_sync_q, rstn_sync_d;
    logic                   tick_prev_q, tick_prev_d;
    logic [CNT_W-1:0]       acc_q, acc_d;
    logic [CNT_W-1:0]       meas_cnt_q, meas_cnt_d;
    logic [CNT_W-1:0]       deassert_q, deassert_d;
    logic                   qual_q, qual_d;
    logic                   freq_err_q, freq_err_d;
    logic                   glitch_q, glitch_d;
    ch_state_t              ch_state_q, ch_state_d;

    logic             tick_edge;
    logic             rst_sync;
    logic             running;
    logic             qualified;
    logic             out_of_range;
    logic             freq_set;
    logic             glitch_set;
    logic [CNT_W-1:0] acc_plus;

    always_comb begin
        tick_sync_d = {tick_sync_q[SYNC_STAGES-2:0], mon_tick};
        rstn_sync_d = {rstn_sync_q[SYNC_STAGES-2:0], mon_resetn};
        tick_prev_d = tick_sync_q[SYNC_STAGES-1];

        // Both edges of the toggle count: one transition per monitored clock edge.
        tick_edge = tick_sync_q[SYNC_STAGES-1] ^ tick_prev_q;
        rst_sync  = ~rstn_sync_q[SYNC_STAGES-1];
        running   = (ch_state_q == ChRunning);

        // Accumulator value including this cycle's edge, saturating.
        acc_plus = (tick_edge && (acc_q != CntMax)) ? acc_q + CntOne : acc_q;

        acc_d      = (!win_run || win_end) ? '0 : acc_plus;
        meas_cnt_d = win_end ? acc_plus : meas_cnt_q;

        // Qualification: channel must be RUNNING in every cycle of the window.
        qual_d    = (!win_run || win_end) ? 1'b1 : (qual_q & running);
        qualified = qual_q & running;

        out_of_range = (acc_plus < cfg_min) || (acc_plus > cfg_max);
        freq_set     = win_end && qualified && out_of_range;
        freq_err_d   = (freq_err_q & ~clr_err) | freq_set;

        ch_state_d = ch_state_q;
        glitch_set = 1'b0;
        unique case (ch_state_q)
            ChInReset: begin
                if (!rst_sync) begin
                    ch_state_d = ChRunning;
                end
            end
            ChRunning: begin
                if (rst_sync) begin
                    ch_state_d = ChInReset;
                    glitch_set = 1'b1;
                end
            end
            default: ch_state_d = ChInReset;
        endcase
        glitch_d = (glitch_q & ~clr_err) | glitch_set;

        if (rst_sync) begin
            deassert_d = '0;
        end else if (deassert_q != CntMax) begin
            deassert_d = deassert_q + CntOne;
        end else begin
            deassert_d = deassert_q;
        end
    end

    always_ff @(posedge pl_clk0 or posedge pl_reset) begin
        if (pl_reset) begin
            tick_sync_q <= '0;
            rstn_sync_q <= '0;
            tick_prev_q <= 1'b0;
            acc_q       <= '0;
            meas_cnt_q  <= '0;
            deassert_q  <= '0;
            qual_q      <= 1'b1;
            freq_err_q  <= 1'b0;
            glitch_q    <= 1'b0;
            ch_state_q  <= ChInReset;
        end else begin
            tick_sync_q <= tick_sync_d;
            rstn_sync_q <= rstn_sync_d;
            tick_prev_q <= tick_prev_d;
            acc_q       <= acc_d;
            meas_cnt_q  <= meas_cnt_d;
            deassert_q  <= deassert_d;
            qual_q      <= qual_d;
            freq_err_q  <= freq_err_d;
            glitch_q    <= glitch_d;
            ch_state_q  <= ch_state_d;
        end
    end

    assign meas_cnt     = meas_cnt_q;
    assign freq_err     = freq_err_q;
    assign rst_state    = rst_sync;
    assign deassert_cnt = deassert_q;
    assign rst_glitch   = glitch_q;

endmodule

// File: rtl/pl_clk_rst_monitor.sv
// Multi-channel clock-rate and reset health monitor running on pl_clk0.
// Holds the shared measurement-window FSM and counter; each channel is a pl_mon_channel.
//   pl_clk0, pl_reset : reference clock, async active-high reset
//   enable            : 1 = measure, 0 = idle (aborts a window in progress)
//   clr_err           : clears sticky freq_err / rst_glitch
//   mon_tick          : per-channel toggle from the monitored domain
//   mon_resetn        : per-channel monitored-domain reset, active-low
//   cfg_min, cfg_max  : packed per-channel bounds, channel i at [i*CNT_W +: CNT_W]
//   meas_cnt          : packed per-channel counts of the last completed window
//   meas_valid        : one-cycle pulse when meas_cnt updates
//   freq_err          : sticky per-channel rate error
//   rst_state         : per-channel synchronized reset status (1 = in reset)
//   deassert_cnt      : packed per-channel cycles since reset de-assertion
//   rst_glitch        : sticky per-channel reset re-assertion flag
module pl_clk_rst_monitor
    import pl_mon_pkg::*;
#(
    parameter int unsigned NUM_CH      = DefNumCh,
    parameter int unsigned WINDOW      = DefWindow,
    parameter int unsigned CNT_W       = DefCntW,
    parameter int unsigned SYNC_STAGES = DefSyncStages
) (
    input  logic                    pl_clk0,
    input  logic                    pl_reset,
    input  logic                    enable,
    input  logic                    clr_err,
    input  logic [NUM_CH-1:0]       mon_tick,
    input  logic [NUM_CH-1:0]       mon_resetn,
    input  logic [NUM_CH*CNT_W-1:0] cfg_min,
    input  logic [NUM_CH*CNT_W-1:0] cfg_max,
    output logic [NUM_CH*CNT_W-1:0] meas_cnt,
    output logic                    meas_valid,
    output logic [NUM_CH-1:0]       freq_err,
    output logic [NUM_CH-1:0]       rst_state,
    output logic [NUM_CH*CNT_W-1:0] deassert_cnt,
    output logic [NUM_CH-1:0]       rst_glitch
);

    localparam int unsigned     WinW    = $clog2(WINDOW);
    localparam logic [WinW-1:0] WinLast = WinW'(WINDOW - 1);
    localparam logic [WinW-1:0] WinOne  = WinW'(1);

    win_state_t      win_state_q, win_state_d;
    logic [WinW-1:0] win_cnt_q, win_cnt_d;
    logic            meas_valid_q, meas_valid_d;
    logic            win_run;
    logic            win_end;

    always_comb begin
        win_state_d = win_state_q;
        win_cnt_d   = win_cnt_q;
        win_run     = 1'b0;
        win_end     = 1'b0;
        unique case (win_state_q)
            WinIdle: begin
                if (enable) begin
                    win_state_d = WinMeasure;
                    win_cnt_d   = '0;
                end
            end
            WinMeasure: begin
                if (!enable) begin
                    // Abort: channels clear their accumulators, meas_cnt holds.
                    win_state_d = WinIdle;
                    win_cnt_d   = '0;
                end else begin
                    win_run = 1'b1;
                    if (win_cnt_q == WinLast) begin
                        win_end   = 1'b1;
                        win_cnt_d = '0;
                    end else begin
                        win_cnt_d = win_cnt_q + WinOne;
                    end
                end
            end
            default: win_state_d = WinIdle;
        endcase
        meas_valid_d = win_end;
    end

    always_ff @(posedge pl_clk0 or posedge pl_reset) begin
        if (pl_reset) begin
            win_state_q  <= WinIdle;
            win_cnt_q    <= '0;
            meas_valid_q <= 1'b0;
        end else begin
            win_state_q  <= win_state_d;
            win_cnt_q    <= win_cnt_d;
            meas_valid_q <= meas_valid_d;
        end
    end

    assign meas_valid = meas_valid_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pl_mon_channel #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_ch (
            .pl_clk0      (pl_clk0),
            .pl_reset     (pl_reset),
            .clr_err      (clr_err),
            .win_run      (win_run),
            .win_end      (win_end),
            .mon_tick     (mon_tick[g]),
            .mon_resetn   (mon_resetn[g]),
            .cfg_min      (cfg_min[g*CNT_W +: CNT_W]),
            .cfg_max      (cfg_max[g*CNT_W +: CNT_W]),
            .meas_cnt     (meas_cnt[g*CNT_W +: CNT_W]),
            .freq_err     (freq_err[g]),
            .rst_state    (rst_state[g]),
            .deassert_cnt (deassert_cnt[g*CNT_W +: CNT_W]),
            .rst_glitch   (rst_glitch[g])
        );
    end

endmodule

// File: doc/pl_clk_rst_monitor.md
# pl_clk_rst_monitor

Synthesizable multi-channel clock and reset health monitor. It runs in the `pl_clk0` domain of the extensible platform. For each monitored PL domain, it measures the clock rate against a programmable window, checks the rate against per-channel bounds, and tracks reset de-assertion timing and reset glitches. Results are exposed as status registers for software and for simulation checks.

## Interface
- `NUM_CH`, 4: number of monitored channels (1..16).
- `WINDOW`, 1024: `pl_clk0` cycles per measurement window (≥ 4).
- `CNT_W`, 16: width of every counter and bound.
- `SYNC_STAGES`, 2: synchronizer depth (≥ 2).
- `pl_clk0` in 1: reference clock; the only clock of the block.
- `pl_reset` in 1: asynchronous reset, active-high.
- `enable` in 1: 1 = measure; 0 = idle and abort the current window.
- `clr_err` in 1: single-cycle clear of the sticky flags.
- `mon_tick` in NUM_CH: per-channel toggle. The flop in the monitored domain inverts on every monitored clock edge.
- `mon_resetn` in NUM_CH: per-channel monitored-domain reset, active-low, asynchronous to `pl_clk0`.
- `cfg_min` in NUM_CH*CNT_W: per-channel lower bound on the window count; channel i occupies `[i*CNT_W +: CNT_W]`.
- `cfg_max` in NUM_CH*CNT_W: per-channel upper bound on the window count, packed the same way.
- `meas_cnt` out NUM_CH*CNT_W: count from the last completed window.
- `meas_valid` out 1: one-cycle pulse when `meas_cnt` updates.
- `freq_err` out NUM_CH: sticky; last qualified count fell outside `[cfg_min, cfg_max]`.
- `rst_state` out NUM_CH: synchronized reset status; 1 = monitored domain is in reset.
- `deassert_cnt` out NUM_CH*CNT_W: `pl_clk0` cycles since the last reset de-assertion; saturates.
- `rst_glitch` out NUM_CH: sticky; reset re-asserted after a de-assertion.

## Operation
- **Synchronizers.** `mon_tick` and `mon_resetn` each pass through a `SYNC_STAGES` flop chain.
  - Tick synchronizer flops reset to 0.
  - Reset synchronizer flops reset to 0, so a channel reads as "in reset".
- **Edge detection.** One register past the synchronizer; any transition (rise or fall) counts as one monitored clock period.
- **Rate limit.** Monitored clock frequency must be below f(`pl_clk0`)/2. Faster clocks undercount; this is not flagged.
- **Window FSM.** States are IDLE and MEASURE.
  - IDLE → MEASURE when `enable` is 1. The window counter starts at 0.
  - In MEASURE, the window counter increments every cycle.
  - At count `WINDOW-1`:
    - each accumulator, including an edge in that cycle, is latched into `meas_cnt`;
    - accumulators clear;
    - the window counter wraps to 0;
    - `meas_valid` pulses on the next cycle.
  - MEASURE → IDLE when `enable` is 0. Accumulators clear, no `meas_valid` is produced, and `meas_cnt` holds.
- **Accumulators.** Saturate at 2^CNT_W−1; they do not wrap.
- **Channel reset FSM.** States are IN_RESET and RUNNING.
  - IN_RESET → RUNNING when the synchronized reset goes to 0. `deassert_cnt` restarts from 0 and then increments by 1 per cycle, saturating.
  - RUNNING → IN_RESET when the synchronized reset re-asserts. `rst_glitch` sets and `deassert_cnt` is forced to 0.
- **Rate qualification.** A window is qualified for a channel only if that channel stayed RUNNING for the whole window.
  - The bound check runs only on qualified windows.
  - An unqualified window still updates `meas_cnt` but leaves `freq_err` unchanged.
- **Sticky flags.** `clr_err` clears `freq_err` and `rst_glitch`. If a set and `clr_err` occur in the same cycle, the set wins.
- **Bad bounds.** If `cfg_min > cfg_max`, every qualified window flags an error.

## Timing
- **Reset values** (all asynchronous):
  - `meas_cnt`=0, `meas_valid`=0, `freq_err`=0, `deassert_cnt`=0, `rst_glitch`=0.
  - `rst_state`=all 1s.
  - Window FSM in IDLE; all channels in IN_RESET.
- **Edge latency.** A `mon_tick` transition enters the accumulator `SYNC_STAGES`+1 cycles later.
- **Reset latency.**
  - `mon_resetn` rising → `rst_state` falls after `SYNC_STAGES` cycles.
  - `deassert_cnt`=1 on the following cycle.
- **Window outputs.**
  - `freq_err` updates in the same cycle that `meas_valid` is high.
  - `meas_cnt` is stable from `meas_valid` until the next `meas_valid`.
- **Reset mid-window.** `pl_reset` asserted mid-window returns everything to reset values immediately. No partial result is produced.

## Structure
- **Package `pl_mon_pkg`:**
  - `win_state_t` (IDLE, MEASURE);
  - `ch_state_t` (IN_RESET, RUNNING);
  - default parameter constants.
- **Sub-module `pl_mon_channel`:** one per channel, generated `NUM_CH` times. Contains the synchronizers, edge detect, accumulator, reset FSM, `deassert_cnt`, bound check and sticky flags.
- **Top level:** holds the window FSM and counter, and the `meas_valid` register.

## Test plan
Unless noted, all scenarios use NUM_CH=2, WINDOW=100, CNT_W=16, SYNC_STAGES=2.

1. **Reset values.** Pulse `pl_reset` mid-window → all outputs at reset values the same cycle; `rst_state`=2'b11.
2. **Nominal rate.** ch0 `mon_tick` toggles every 4 cycles, `mon_resetn`=1, bounds [24,26], `enable`=1 → `meas_valid` every 100 cycles; `meas_cnt[0]`=25 from the second window on; `freq_err[0]`=0.
3. **Stopped clock.** ch1 tick held constant, bounds [24,26], RUNNING → `meas_cnt[1]`=0 and `freq_err[1]`=1. The flag stays 1 until `clr_err`. With `clr_err` pulsed in the same cycle as a set → flag remains 1.
4. **Reset glitch.** ch0 `mon_resetn` rises, then falls 50 cycles later → `deassert_cnt` peaks at ~50 then goes to 0; `rst_glitch[0]`=1; that window is unqualified, so `freq_err` is unchanged.
5. **Enable abort.** `enable` dropped at window cycle 60 and restored 10 cycles later → no `meas_valid` for the aborted window; the next `meas_valid` comes exactly 100 cycles after re-enable.
6. **Saturation.** CNT_W=4, tick toggling every 2 cycles → `meas_cnt`=15; `deassert_cnt` holds at 15.
